// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART command controller: opcodes, FSM states
// and the fixed register-file slots used for ALU operands.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_OP_A,
        ST_OP_B,
        ST_ALU_FUN,
        ST_ALU_WAIT,
        ST_SEND_LO,
        ST_SEND_HI
    } state_t;

    // States that consume command bytes; any other state discards incoming bytes.
    function automatic logic is_collecting(input state_t s);
        return (s == ST_IDLE)  || (s == ST_WR_ADDR) || (s == ST_WR_DATA) ||
               (s == ST_RD_ADDR) || (s == ST_OP_A) || (s == ST_OP_B) ||
               (s == ST_ALU_FUN);
    endfunction

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == CMD_RF_WR) || (b == CMD_RF_RD) ||
               (b == CMD_ALU_OP) || (b == CMD_ALU_NOP);
    endfunction

endpackage

// File: rtl/rx_cmd_ctrl.sv
// Decodes framed UART commands into register-file writes/reads and ALU runs,
// and streams read data / ALU results (low byte first) into the TX FIFO.
module rx_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic                     RX_PAR_ERR,
    input  logic                     RX_STP_ERR,
    output logic                     RF_WrEn,
    output logic                     RF_RdEn,
    output logic [ADDR_WIDTH-1:0]    RF_Address,
    output logic [DATA_WIDTH-1:0]    RF_WrData,
    input  logic [DATA_WIDTH-1:0]    RF_RdData,
    input  logic                     RF_RdData_VLD,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLK_GATE_EN,
    input  logic                     FIFO_FULL,
    output logic                     WR_INC,
    output logic [DATA_WIDTH-1:0]    WR_DATA,
    output logic                     CMD_DROP
);

    state_t                   state, state_nx;
    logic                     alu_path, alu_nx;
    logic                     pending, pending_nx;
    logic [ALU_OUT_WIDTH-1:0] result, result_nx;

    logic                     rf_wr_en_nx, rf_rd_en_nx, alu_en_nx, wr_inc_nx, cmd_drop_nx;
    logic                     clk_gate_nx;
    logic [ADDR_WIDTH-1:0]    rf_addr_nx;
    logic [DATA_WIDTH-1:0]    rf_wr_data_nx, wr_data_nx;
    logic [3:0]               alu_fun_nx;

    logic acc, err;
    assign acc = RX_D_VLD & ~RX_PAR_ERR & ~RX_STP_ERR;
    assign err = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);

    // State register; every output is registered here so strobes are glitch-free.
    // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            alu_path    <= 1'b0;
            pending     <= 1'b0;
            result      <= '0;
            RF_WrEn     <= 1'b0;
            RF_RdEn     <= 1'b0;
            RF_Address  <= '0;
            RF_WrData   <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            WR_INC      <= 1'b0;
            WR_DATA     <= '0;
            CMD_DROP    <= 1'b0;
        end else begin
            state       <= state_nx;
            alu_path    <= alu_nx;
            pending     <= pending_nx;
            result      <= result_nx;
            RF_WrEn     <= rf_wr_en_nx;
            RF_RdEn     <= rf_rd_en_nx;
            RF_Address  <= rf_addr_nx;
            RF_WrData   <= rf_wr_data_nx;
            ALU_EN      <= alu_en_nx;
            ALU_FUN     <= alu_fun_nx;
            CLK_GATE_EN <= clk_gate_nx;
            WR_INC      <= wr_inc_nx;
            WR_DATA     <= wr_data_nx;
            CMD_DROP    <= cmd_drop_nx;
        end
    end

    // Next-state logic. An errored byte in a collecting state aborts to IDLE.
    // NOTE: defaults at the top of each always_comb prevent latch inference.
    always_comb begin
        state_nx = state;
        alu_nx   = alu_path;
        case (state)
            ST_IDLE: begin
                if (acc) begin
                    case (RX_P_DATA)
                        CMD_RF_WR:   state_nx = ST_WR_ADDR;
                        CMD_RF_RD:   state_nx = ST_RD_ADDR;
                        CMD_ALU_OP:  begin state_nx = ST_OP_A;    alu_nx = 1'b1; end
                        CMD_ALU_NOP: begin state_nx = ST_ALU_FUN; alu_nx = 1'b1; end
                        default:     state_nx = ST_IDLE;
                    endcase
                end
            end
            ST_WR_ADDR:  if (RX_D_VLD) state_nx = acc ? ST_WR_DATA  : ST_IDLE;
            ST_WR_DATA:  if (RX_D_VLD) state_nx = ST_IDLE;
            ST_RD_ADDR:  if (RX_D_VLD) state_nx = acc ? ST_RD_WAIT  : ST_IDLE;
            ST_OP_A:     if (RX_D_VLD) state_nx = acc ? ST_OP_B     : ST_IDLE;
            ST_OP_B:     if (RX_D_VLD) state_nx = acc ? ST_ALU_FUN  : ST_IDLE;
            ST_ALU_FUN:  if (RX_D_VLD) state_nx = acc ? ST_ALU_WAIT : ST_IDLE;
            ST_RD_WAIT:  if (RF_RdData_VLD) state_nx = ST_SEND_LO;
            ST_ALU_WAIT: if (ALU_OUT_VLD)   state_nx = ST_SEND_LO;
            ST_SEND_LO:  if (!pending) state_nx = alu_path ? ST_SEND_HI : ST_IDLE;
            ST_SEND_HI:  if (!pending) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
        if (state_nx == ST_IDLE) alu_nx = 1'b0;
    end

    // Output logic: next values of the registered outputs. `pending` marks a
    // SEND state whose byte has not yet been pushed because the FIFO was full.
    always_comb begin
        rf_wr_en_nx   = 1'b0;
        rf_rd_en_nx   = 1'b0;
        alu_en_nx     = 1'b0;
        wr_inc_nx     = 1'b0;
        rf_addr_nx    = RF_Address;
        rf_wr_data_nx = RF_WrData;
        alu_fun_nx    = ALU_FUN;
        wr_data_nx    = WR_DATA;
        result_nx     = result;
        pending_nx    = pending;

        if (is_collecting(state))
            cmd_drop_nx = err | ((state == ST_IDLE) && acc && !is_opcode(RX_P_DATA));
        else
            cmd_drop_nx = RX_D_VLD;

        clk_gate_nx = (state_nx == ST_ALU_FUN) || (state_nx == ST_ALU_WAIT) ||
                      (alu_nx && ((state_nx == ST_SEND_LO) || (state_nx == ST_SEND_HI)));

        case (state)
            ST_WR_ADDR: if (acc) rf_addr_nx = RX_P_DATA[ADDR_WIDTH-1:0];
            ST_WR_DATA: if (acc) begin
                rf_wr_data_nx = RX_P_DATA;
                rf_wr_en_nx   = 1'b1;
            end
            ST_RD_ADDR: if (acc) begin
                rf_addr_nx  = RX_P_DATA[ADDR_WIDTH-1:0];
                rf_rd_en_nx = 1'b1;
            end
            ST_OP_A, ST_OP_B: if (acc) begin
                rf_addr_nx    = (state == ST_OP_A) ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR);
                rf_wr_data_nx = RX_P_DATA;
                rf_wr_en_nx   = 1'b1;
            end
            ST_ALU_FUN: if (acc) begin
                alu_fun_nx = RX_P_DATA[3:0];
                alu_en_nx  = 1'b1;
            end
            ST_RD_WAIT: if (RF_RdData_VLD) begin
                result_nx  = ALU_OUT_WIDTH'(RF_RdData);
                wr_data_nx = RF_RdData;
                wr_inc_nx  = !FIFO_FULL;
                pending_nx = FIFO_FULL;
            end
            ST_ALU_WAIT: if (ALU_OUT_VLD) begin
                result_nx  = ALU_OUT;
                wr_data_nx = ALU_OUT[DATA_WIDTH-1:0];
                wr_inc_nx  = !FIFO_FULL;
                pending_nx = FIFO_FULL;
            end
            ST_SEND_LO: begin
                if (pending) begin
                    if (!FIFO_FULL) begin
                        wr_data_nx = result[DATA_WIDTH-1:0];
                        wr_inc_nx  = 1'b1;
                        pending_nx = 1'b0;
                    end
                end else if (alu_path) begin
                    wr_data_nx = result[ALU_OUT_WIDTH-1:DATA_WIDTH];
                    wr_inc_nx  = !FIFO_FULL;
                    pending_nx = FIFO_FULL;
                end
            end
            ST_SEND_HI: if (pending && !FIFO_FULL) begin
                wr_data_nx = result[ALU_OUT_WIDTH-1:DATA_WIDTH];
                wr_inc_nx  = 1'b1;
                pending_nx = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Directed self-checking bench for rx_cmd_ctrl: one task per scenario,
// inputs driven and outputs sampled on the falling edge.
module tb_rx_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD, RX_PAR_ERR, RX_STP_ERR;
    logic        RF_WrEn, RF_RdEn;
    logic [3:0]  RF_Address;
    logic [7:0]  RF_WrData, RF_RdData;
    logic        RF_RdData_VLD;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD, CLK_GATE_EN, FIFO_FULL, WR_INC, CMD_DROP;
    logic [7:0]  WR_DATA;

    int checks = 0;
    int failures = 0;

    logic [11:0] rf_wr_q[$];
    logic [7:0]  fifo_q[$];
    int          drop_cnt, alu_cnt;

    always #5 CLK = ~CLK;

    rx_cmd_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RX_PAR_ERR(RX_PAR_ERR), .RX_STP_ERR(RX_STP_ERR),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
        .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN), .FIFO_FULL(FIFO_FULL),
        .WR_INC(WR_INC), .WR_DATA(WR_DATA), .CMD_DROP(CMD_DROP)
    );

    // Event log of every strobe, sampled mid-cycle.
    always @(negedge CLK) begin
        if (!RST) begin
            if (RF_WrEn)  rf_wr_q.push_back({RF_Address, RF_WrData});
            if (WR_INC)   fifo_q.push_back(WR_DATA);
            if (CMD_DROP) drop_cnt++;
            if (ALU_EN)   alu_cnt++;
        end
    end

    task automatic clear_log();
        rf_wr_q.delete();
        fifo_q.delete();
        drop_cnt = 0;
        alu_cnt  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic par = 1'b0, input logic stp = 1'b0);
        @(negedge CLK);
        RX_P_DATA = b; RX_D_VLD = 1'b1; RX_PAR_ERR = par; RX_STP_ERR = stp;
        @(negedge CLK);
        RX_D_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_STP_ERR = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic wait_fifo(input int n, input string tag);
        int k = 0;
        while (fifo_q.size() < n && k < 50) begin @(negedge CLK); k++; end
        checks++;
        if (fifo_q.size() < n) begin
            failures++;
            $display("FAIL %s timeout: fifo writes=%0d expected=%0d", tag, fifo_q.size(), n);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #12;
        checks++;
        if ({RF_WrEn, RF_RdEn, ALU_EN, WR_INC, CMD_DROP, CLK_GATE_EN} !== 6'b0) begin
            failures++; $display("FAIL reset_strobes got=%b exp=000000",
                {RF_WrEn, RF_RdEn, ALU_EN, WR_INC, CMD_DROP, CLK_GATE_EN});
        end
        checks++;
        if ({RF_Address, RF_WrData, ALU_FUN, WR_DATA} !== 24'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=000000",
                {RF_Address, RF_WrData, ALU_FUN, WR_DATA});
        end
        @(negedge CLK);
        RST = 1'b0;
        idle(2);
    endtask

    task automatic test_write();
        clear_log();
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        checks++;
        if (RF_WrEn !== 1'b1 || RF_Address !== 4'h5 || RF_WrData !== 8'h3C) begin
            failures++; $display("FAIL write_strobe got en=%b addr=%h data=%h exp en=1 addr=5 data=3c",
                RF_WrEn, RF_Address, RF_WrData);
        end
        @(negedge CLK);
        checks++;
        if (RF_WrEn !== 1'b0) begin
            failures++; $display("FAIL write_width got en=%b exp=0", RF_WrEn);
        end
        idle(3);
        checks++;
        if (rf_wr_q.size() != 1 || fifo_q.size() != 0 || drop_cnt != 0) begin
            failures++; $display("FAIL write_count got wr=%0d fifo=%0d drop=%0d exp 1/0/0",
                rf_wr_q.size(), fifo_q.size(), drop_cnt);
        end
    endtask

    task automatic test_read(input logic [7:0] addr, input logic [7:0] data, input string tag);
        clear_log();
        send_byte(8'hBB);
        send_byte(addr);
        checks++;
        if (RF_RdEn !== 1'b1 || RF_Address !== addr[3:0]) begin
            failures++; $display("FAIL %s rd_strobe got en=%b addr=%h exp en=1 addr=%h",
                tag, RF_RdEn, RF_Address, addr[3:0]);
        end
        idle(2);
        RF_RdData = data; RF_RdData_VLD = 1'b1;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
        checks++;
        if (WR_INC !== 1'b1 || WR_DATA !== data) begin
            failures++; $display("FAIL %s rd_latency got inc=%b data=%h exp inc=1 data=%h",
                tag, WR_INC, WR_DATA, data);
        end
        idle(3);
        checks++;
        if (fifo_q.size() != 1 || rf_wr_q.size() != 0 || CLK_GATE_EN !== 1'b0) begin
            failures++; $display("FAIL %s rd_count got fifo=%0d wr=%0d gate=%b exp 1/0/0",
                tag, fifo_q.size(), rf_wr_q.size(), CLK_GATE_EN);
        end
    endtask

    task automatic test_alu_op();
        clear_log();
        send_byte(8'hCC);
        send_byte(8'h07);
        checks++;
        if (CLK_GATE_EN !== 1'b0) begin
            failures++; $display("FAIL alu_gate_opb got=%b exp=0", CLK_GATE_EN);
        end
        send_byte(8'h03);
        checks++;
        if (CLK_GATE_EN !== 1'b1 || ALU_EN !== 1'b0) begin
            failures++; $display("FAIL alu_gate_fun got gate=%b en=%b exp 1/0", CLK_GATE_EN, ALU_EN);
        end
        send_byte(8'h00);
        checks++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h0) begin
            failures++; $display("FAIL alu_en got en=%b fun=%h exp en=1 fun=0", ALU_EN, ALU_FUN);
        end
        checks++;
        if (rf_wr_q.size() != 2 || rf_wr_q[0] !== 12'h007 || rf_wr_q[1] !== 12'h103) begin
            failures++; $display("FAIL alu_operands got n=%0d first=%h second=%h exp 2 007 103",
                rf_wr_q.size(), rf_wr_q[0], rf_wr_q[1]);
        end
        idle(2);
        ALU_OUT = 16'h000A; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        checks++;
        if (WR_INC !== 1'b1 || WR_DATA !== 8'h0A) begin
            failures++; $display("FAIL alu_lo got inc=%b data=%h exp inc=1 data=0a", WR_INC, WR_DATA);
        end
        @(negedge CLK);
        checks++;
        if (WR_INC !== 1'b1 || WR_DATA !== 8'h00 || CLK_GATE_EN !== 1'b1) begin
            failures++; $display("FAIL alu_hi got inc=%b data=%h gate=%b exp 1/00/1",
                WR_INC, WR_DATA, CLK_GATE_EN);
        end
        @(negedge CLK);
        checks++;
        if (WR_INC !== 1'b0 || CLK_GATE_EN !== 1'b0 || fifo_q.size() != 2) begin
            failures++; $display("FAIL alu_done got inc=%b gate=%b fifo=%0d exp 0/0/2",
                WR_INC, CLK_GATE_EN, fifo_q.size());
        end
    endtask

    task automatic test_par_err();
        clear_log();
        send_byte(8'hAA);
        send_byte(8'h02, 1'b1, 1'b0);
        checks++;
        if (CMD_DROP !== 1'b1) begin
            failures++; $display("FAIL par_drop got=%b exp=1", CMD_DROP);
        end
        @(negedge CLK);
        checks++;
        if (CMD_DROP !== 1'b0) begin
            failures++; $display("FAIL par_drop_width got=%b exp=0", CMD_DROP);
        end
        idle(2);
        checks++;
        if (rf_wr_q.size() != 0) begin
            failures++; $display("FAIL par_no_write got=%0d exp=0", rf_wr_q.size());
        end
        test_read(8'h02, 8'h5A, "after_par");
    endtask

    task automatic test_fifo_full();
        clear_log();
        send_byte(8'hDD);
        send_byte(8'h02);
        checks++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== 4'h2 || rf_wr_q.size() != 0) begin
            failures++; $display("FAIL nop_en got en=%b fun=%h wr=%0d exp 1/2/0",
                ALU_EN, ALU_FUN, rf_wr_q.size());
        end
        idle(1);
        @(negedge CLK);
        FIFO_FULL = 1'b1; ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
        @(negedge CLK);
        ALU_OUT_VLD = 1'b0;
        idle(3);
        send_byte(8'h55);
        idle(4);
        checks++;
        if (fifo_q.size() != 0 || drop_cnt != 1) begin
            failures++; $display("FAIL full_stall got fifo=%0d drop=%0d exp 0/1", fifo_q.size(), drop_cnt);
        end
        FIFO_FULL = 1'b0;
        wait_fifo(2, "full_release");
        idle(2);
        checks++;
        if (fifo_q.size() != 2 || fifo_q[0] !== 8'h34 || fifo_q[1] !== 8'h12) begin
            failures++; $display("FAIL full_order got n=%0d b0=%h b1=%h exp 2 34 12",
                fifo_q.size(), fifo_q[0], fifo_q[1]);
        end
    endtask

    task automatic test_bad_opcode();
        clear_log();
        send_byte(8'h12);
        checks++;
        if (CMD_DROP !== 1'b1) begin
            failures++; $display("FAIL bad_op_drop got=%b exp=1", CMD_DROP);
        end
        send_byte(8'hAA);
        send_byte(8'h1E);
        send_byte(8'h77);
        idle(2);
        checks++;
        if (rf_wr_q.size() != 1 || rf_wr_q[0] !== 12'hE77 || drop_cnt != 1) begin
            failures++; $display("FAIL bad_op_then_write got n=%0d entry=%h drop=%0d exp 1 e77 1",
                rf_wr_q.size(), rf_wr_q[0], drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hCC);
        send_byte(8'h09);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({RF_WrEn, RF_RdEn, ALU_EN, WR_INC, CMD_DROP, CLK_GATE_EN} !== 6'b0 ||
            {RF_Address, RF_WrData, ALU_FUN, WR_DATA} !== 24'h0) begin
            failures++; $display("FAIL mid_reset got strobes=%b data=%h exp all zero",
                {RF_WrEn, RF_RdEn, ALU_EN, WR_INC, CMD_DROP, CLK_GATE_EN},
                {RF_Address, RF_WrData, ALU_FUN, WR_DATA});
        end
        @(negedge CLK);
        RST = 1'b0;
        clear_log();
        send_byte(8'h04);
        checks++;
        if (CMD_DROP !== 1'b1 || RF_WrEn !== 1'b0) begin
            failures++; $display("FAIL mid_reset_idle got drop=%b wren=%b exp 1/0", CMD_DROP, RF_WrEn);
        end
    endtask

    initial begin
        RX_P_DATA = '0; RX_D_VLD = 1'b0; RX_PAR_ERR = 1'b0; RX_STP_ERR = 1'b0;
        RF_RdData = '0; RF_RdData_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0;
        FIFO_FULL = 1'b0;
        drop_cnt = 0; alu_cnt = 0;
        test_reset();
        test_write();
        test_read(8'h05, 8'h3C, "read");
        test_alu_op();
        test_par_err();
        test_fifo_full();
        test_bad_opcode();
        test_reset_mid();
        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
